// File: rtl/jump_control_block.sv
// Branch/interrupt steering: decodes jump opcodes and picks the PC target. The optional JCB_FLAG_RESTORE_EN macro adds flag restore on RET.
// Zero-cycle combinational outputs; context registers update on rising clk; no backpressure (consumes one instruction per cycle).
module jump_control_block #(
  parameter logic [7:0] ISR_ADDR = 8'hF0,
  parameter int         OPC_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins,
  input  logic        interrupt,
  input  logic [7:0]  current_address,
  input  logic [3:0]  flag_ex,
  output logic        pc_mux_sel,
  output logic [7:0]  jmp_loc
);

  localparam logic [OPC_W-1:0] OPC_JMP = OPC_W'(5'b11000);
  localparam logic [OPC_W-1:0] OPC_JZ  = OPC_W'(5'b11100);
  localparam logic [OPC_W-1:0] OPC_JNZ = OPC_W'(5'b11110);
  localparam logic [OPC_W-1:0] OPC_JC  = OPC_W'(5'b11101);
  localparam logic [OPC_W-1:0] OPC_JNC = OPC_W'(5'b11111);
  localparam logic [OPC_W-1:0] OPC_RET = OPC_W'(5'b10000);

  logic             int_d;
  logic             in_isr;
  logic [7:0]       ret_addr;
  logic [OPC_W-1:0] opc;
  logic [3:0]       cond_flags;
  logic             int_take;
  logic             is_ret;
  logic             jmp_taken;

  assign opc      = ins[19 -: OPC_W];
  assign int_take = interrupt & ~int_d & ~in_isr;
  assign is_ret   = (opc == OPC_RET);

`ifdef JCB_FLAG_RESTORE_EN
  logic [3:0] saved_flags;
  logic       use_saved;

  // Only the first instruction after RET sees the pre-interrupt flags.
  assign cond_flags = use_saved ? saved_flags : flag_ex;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      saved_flags <= 4'h0;
      use_saved   <= 1'b0;
    end else begin
      if (int_take) saved_flags <= flag_ex;
      use_saved <= is_ret & ~int_take;
    end
  end
`else
  assign cond_flags = flag_ex;
`endif

  logic unused_bits;
  assign unused_bits = ^{cond_flags[3:2], ins[14:8]};

  always_comb begin
    jmp_taken = 1'b0;
    case (opc)
      OPC_JMP: jmp_taken = 1'b1;
      OPC_JZ:  jmp_taken = cond_flags[0];
      OPC_JNZ: jmp_taken = ~cond_flags[0];
      OPC_JC:  jmp_taken = cond_flags[1];
      OPC_JNC: jmp_taken = ~cond_flags[1];
      default: jmp_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_mux_sel = 1'b0;
    jmp_loc    = ins[7:0];
    if (!reset) begin
      jmp_loc = 8'h00;
    end else if (int_take) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = ISR_ADDR;
    end else if (is_ret) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = ret_addr;
    end else if (jmp_taken) begin
      pc_mux_sel = 1'b1;
    end
  end

  // The interrupted instruction's own address is saved so it re-executes on return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_d    <= 1'b0;
      in_isr   <= 1'b0;
      ret_addr <= 8'h00;
    end else begin
      int_d <= interrupt;
      if (int_take) begin
        ret_addr <= current_address;
        in_isr   <= 1'b1;
      end else if (is_ret) begin
        in_isr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jump_control_block.sv
// Bench for jump_control_block: vector table plus hand-written reset/interrupt sequences, checked via an expected-result queue.
module tb_jump_control_block;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] ins = 20'h00000;
  logic        interrupt = 1'b0;
  logic [7:0]  current_address = 8'h00;
  logic [3:0]  flag_ex = 4'h0;
  logic        pc_mux_sel;
  logic [7:0]  jmp_loc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jump_control_block dut (
    .clk             (clk),
    .reset           (reset),
    .ins             (ins),
    .interrupt       (interrupt),
    .current_address (current_address),
    .flag_ex         (flag_ex),
    .pc_mux_sel      (pc_mux_sel),
    .jmp_loc         (jmp_loc)
  );

  typedef struct {
    logic [19:0] ins;
    logic        intr;
    logic [7:0]  addr;
    logic [3:0]  flg;
    logic        exp_sel;
    logic [7:0]  exp_loc;
    string       name;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [7:0] loc;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic [19:0] i, logic it, logic [7:0] a, logic [3:0] f,
                              logic s, logic [7:0] l, string n);
    vec_t v;
    v.ins = i; v.intr = it; v.addr = a; v.flg = f;
    v.exp_sel = s; v.exp_loc = l; v.name = n;
    return v;
  endfunction

  task automatic push_exp(logic s, logic [7:0] l, string n);
    exp_t e;
    e.sel = s; e.loc = l; e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: got sel=%0b loc=%02h, required a queued expectation",
               pc_mux_sel, jmp_loc);
    end else begin
      e = sb.pop_front();
      if (pc_mux_sel !== e.sel || jmp_loc !== e.loc) begin
        fails++;
        $display("FAIL %s: got sel=%0b loc=%02h, required sel=%0b loc=%02h",
                 e.name, pc_mux_sel, jmp_loc, e.sel, e.loc);
      end
    end
  endtask

  // One instruction per cycle: drive after the falling edge, check before the rising edge.
  task automatic drive(logic [19:0] i, logic it, logic [7:0] a, logic [3:0] f,
                       logic s, logic [7:0] l, string n);
    @(negedge clk);
    ins = i; interrupt = it; current_address = a; flag_ex = f;
    push_exp(s, l, n);
    #2 check_out();
  endtask

  // Asynchronous reset pulse inside a low clock phase, checked while asserted.
  task automatic reset_pulse(logic [19:0] i, string n);
    @(negedge clk);
    ins = i; interrupt = 1'b0;
    #1 reset = 1'b0;
    push_exp(1'b0, 8'h00, n);
    #1 check_out();
    #1 reset = 1'b1;
  endtask

  initial begin
    // Held in reset from time zero: outputs must be zero even for a JMP
    ins = 20'hC0008;
    push_exp(1'b0, 8'h00, "reset_jmp");
    #2 check_out();
    ins = 20'h00000;
    push_exp(1'b0, 8'h00, "reset_nop");
    #1 check_out();
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back(mk(20'h00000, 1'b1, 8'h01, 4'h0, 1'b1, 8'hF0, "int_accept"));
    vecs.push_back(mk(20'h00008, 1'b1, 8'h02, 4'h0, 1'b0, 8'h08, "int_held"));
    vecs.push_back(mk(20'hC0008, 1'b0, 8'h03, 4'h8, 1'b1, 8'h08, "jmp"));
    vecs.push_back(mk(20'hF8008, 1'b0, 8'h03, 4'h8, 1'b1, 8'h08, "jnc_taken"));
    vecs.push_back(mk(20'hF8008, 1'b0, 8'h03, 4'hA, 1'b0, 8'h08, "jnc_not"));
    vecs.push_back(mk(20'hE0020, 1'b0, 8'h03, 4'h1, 1'b1, 8'h20, "jz_taken"));
    vecs.push_back(mk(20'hE0020, 1'b0, 8'h03, 4'h0, 1'b0, 8'h20, "jz_not"));
    vecs.push_back(mk(20'hF0030, 1'b0, 8'h03, 4'h0, 1'b1, 8'h30, "jnz_taken"));
    vecs.push_back(mk(20'hF0030, 1'b0, 8'h03, 4'h1, 1'b0, 8'h30, "jnz_not"));
    vecs.push_back(mk(20'hE8040, 1'b0, 8'h03, 4'h2, 1'b1, 8'h40, "jc_taken"));
    vecs.push_back(mk(20'hE8040, 1'b0, 8'h03, 4'h0, 1'b0, 8'h40, "jc_not"));
    vecs.push_back(mk(20'h00055, 1'b1, 8'h03, 4'h0, 1'b0, 8'h55, "nested_int_dropped"));
    vecs.push_back(mk(20'h80008, 1'b0, 8'h04, 4'h0, 1'b1, 8'h01, "ret"));
    vecs.push_back(mk(20'h80008, 1'b0, 8'h05, 4'h0, 1'b1, 8'h01, "ret_outside_isr"));
    vecs.push_back(mk(20'hC0077, 1'b1, 8'h09, 4'h0, 1'b1, 8'hF0, "int_beats_jmp"));
    vecs.push_back(mk(20'h80000, 1'b0, 8'h0A, 4'h0, 1'b1, 8'h09, "ret_to_jmp"));
    vecs.push_back(mk(20'hA0012, 1'b0, 8'h0B, 4'h0, 1'b0, 8'h12, "nonjump_10100"));
    vecs.push_back(mk(20'hC8013, 1'b0, 8'h0B, 4'h0, 1'b0, 8'h13, "nonjump_11001"));
    vecs.push_back(mk(20'h80008, 1'b1, 8'h0B, 4'h0, 1'b1, 8'hF0, "int_beats_ret"));
    vecs.push_back(mk(20'h80000, 1'b0, 8'h0C, 4'h0, 1'b1, 8'h0B, "ret_to_ret"));

    foreach (vecs[k])
      drive(vecs[k].ins, vecs[k].intr, vecs[k].addr, vecs[k].flg,
            vecs[k].exp_sel, vecs[k].exp_loc, vecs[k].name);

    // Reset mid-ISR discards the saved context and re-enables interrupts
    drive(20'h00000, 1'b1, 8'h33, 4'h0, 1'b1, 8'hF0, "int_before_reset");
    reset_pulse(20'hC0008, "reset_mid_isr");
    drive(20'h80008, 1'b1, 8'h44, 4'h0, 1'b1, 8'hF0, "int_after_reset");
    drive(20'h80000, 1'b0, 8'h45, 4'h0, 1'b1, 8'h44, "ret_after_reset_int");

    // RET after a fresh reset returns to address 0
    reset_pulse(20'h00000, "reset_plain");
    drive(20'h80000, 1'b0, 8'h50, 4'h0, 1'b1, 8'h00, "ret_cleared_addr");
    drive(20'hE0021, 1'b0, 8'h51, 4'h1, 1'b1, 8'h21, "jz_after_ret_z");

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jump_control_block.md
Name: jump_control_block

Overview:
- Branch/interrupt steering unit for the 8-bit-address, 20-bit-instruction pipelined processor.
- Decodes jump-class opcodes in the fetched instruction and evaluates conditions against the ALU flags from EX.
- Tells the PC mux to load a target address (`pc_mux_sel`, `jmp_loc`) instead of PC+1.
- Handles a single-level hardware interrupt: vectors to a fixed ISR address, saves the return address and flags, restores them on RET.

Parameters:
- ISR_ADDR, 8'hF0, interrupt vector loaded into the PC on an accepted interrupt.
- OPC_W, 5, opcode field width; the opcode is `ins[19:15]`.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ins  in  20  current instruction; `[19:15]` opcode, `[7:0]` jump target.
- interrupt  in  1  external interrupt request, level input, edge-detected internally.
- current_address  in  8  address of the instruction presented on `ins`.
- flag_ex  in  4  flags from EX stage: `[0]` Z, `[1]` C, `[3:2]` unused by this block.
- pc_mux_sel  out  1  1 = PC loads `jmp_loc`; 0 = PC increments.
- jmp_loc  out  8  jump/vector/return target.

Behaviour:
- Opcodes (`ins[19:15]`):
  - 11000 JMP: unconditional.
  - 11100 JZ: taken if Z=1.
  - 11110 JNZ: taken if Z=0.
  - 11101 JC: taken if C=1.
  - 11111 JNC: taken if C=0.
  - 10000 RET: return from interrupt.
  - All other opcodes are non-jump.
- Outputs are combinational from inputs and internal registers (zero-cycle latency). Registered state updates on the rising clk edge.
- Internal registers:
  - `int_d`: interrupt delayed one cycle.
  - `ret_addr[7:0]`
  - `saved_flags[3:0]`
  - `in_isr`
- Interrupt acceptance: `int_take = interrupt & ~int_d & ~in_isr`.
  - A held interrupt is accepted once.
  - Interrupts arriving while `in_isr`=1 are dropped (no nesting, no queueing).
- Priority, highest first: reset > `int_take` > RET > conditional/unconditional jump > none.
- `int_take`:
  - `pc_mux_sel`=1, `jmp_loc`=ISR_ADDR.
  - At the clock edge: `ret_addr`<=`current_address`, `saved_flags`<=`flag_ex`, `in_isr`<=1.
  - The interrupted instruction is re-fetched on return; no increment is applied.
- RET:
  - `pc_mux_sel`=1, `jmp_loc`=`ret_addr`.
  - At the clock edge: `in_isr`<=0.
  - RET while `in_isr`=0 still jumps to `ret_addr` (0 after reset).
- Taken jump: `pc_mux_sel`=1, `jmp_loc`=`ins[7:0]`.
- Not-taken or non-jump: `pc_mux_sel`=0, `jmp_loc`=`ins[7:0]` (don't-care value, driven for determinism).
- Flag source for conditions is `flag_ex`, except as modified by the optional feature.
- Reset low (asynchronous):
  - `pc_mux_sel`=0, `jmp_loc`=0 immediately.
  - `int_d`, `ret_addr`, `saved_flags`, `in_isr` all cleared.
  - Reset mid-ISR clears `in_isr` and discards the saved context.
- Interrupt coincident with a jump or RET: the interrupt wins.
  - `ret_addr` captures `current_address`, so the jump/RET instruction is re-executed after return.
- No X propagation: all outputs are defined for any `ins`.

Optional Feature:
- Macro: `JCB_FLAG_RESTORE_EN`.
- Defined:
  - On RET, a one-cycle flag `use_saved` is set.
  - In the cycle after RET, conditional jumps evaluate `saved_flags` instead of `flag_ex`, restoring pre-interrupt condition state.
  - `use_saved` is cleared on reset.
- Undefined:
  - `saved_flags` is not implemented.
  - Conditions always use `flag_ex`.
  - `use_saved` logic is absent.

Test Plan:
- Reset pulse low mid-cycle with `ins`=20'h00000 → `pc_mux_sel`=0, `jmp_loc`=00 immediately; after release, state is cleared.
- `interrupt` 0→1, `current_address`=01, `ins`=00000 → `pc_mux_sel`=1, `jmp_loc`=F0 in that cycle; after the edge `ret_addr`=01. Holding `interrupt` high for a second cycle with `ins`=20'h00008 → `pc_mux_sel`=0.
- `ins`=20'hC0008 (JMP), `flag_ex`=8 → `pc_mux_sel`=1, `jmp_loc`=08.
- `ins`=20'h80008 (RET), `current_address`=04 after the interrupt above → `pc_mux_sel`=1, `jmp_loc`=01; `in_isr` cleared.
- `ins`=20'hF8008 (JNC): `flag_ex`=8 (C=0) → `pc_mux_sel`=1, `jmp_loc`=08; `flag_ex`=A (C=1) → `pc_mux_sel`=0.
- JZ/JNZ/JC with Z/C toggled, plus a second interrupt while `in_isr`=1 → taken/not-taken as decoded; the nested interrupt is ignored (`pc_mux_sel` follows `ins`).
